i2c_eeprom_slave: RTL and testbench

- I2C target (responder) modelling a 256-byte serial EEPROM.
- Sits at the far end of the sda/scl pair driven by the APB-to-I2C bridge. Gives the bridge a synthesizable, cycle-checkable counterpart for write, current-address read and random read.
- Oversamples scl/sda on the system clock and drives sda open-drain through an output-enable.

---
 rtl/i2c_eeprom_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_slave.sv
// I2C target that behaves like a 256-byte serial EEPROM (write, current-address read, random read).
// Define I2C_EEPROM_WP_EN to add the wp write-protect input.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         AW          = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
`ifdef I2C_EEPROM_WP_EN
  input  logic          wp,
`endif
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_pulse,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    DEVADDR,
    DEVACK,
    WADDR,
    WACK,
    WDATA,
    RDATA,
    RACK
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          rw, rw_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          sda_oe_nxt, busy_nxt, wr_pulse_nxt;
  logic [AW-1:0] wr_addr_nxt;
  logic [7:0]    wr_data_nxt;
  logic          mem_we;
  logic          wp_block;
  logic          byte_done, addr_match, shifting;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] mem_rd;

`ifdef I2C_EEPROM_WP_EN
  assign wp_block = wp;
`else
  assign wp_block = 1'b0;
`endif

  // Synchronizers reset to 1 so an idle bus never looks like a START after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & sda_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_q & sda_s;

  assign byte_done  = (bit_cnt == 4'd8);
  assign addr_match = (shreg[7:1] == DEV_ADDR);
  assign shifting   = (state == DEVADDR) || (state == WADDR) || (state == WDATA);
  assign mem_rd     = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A NACK from the master is seen on the rise, so any fall reached in RACK means ACK.
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = DEVADDR;
    end else begin
      case (state)
        DEVADDR: if (scl_fall && byte_done) state_nxt = addr_match ? DEVACK : IDLE;
        DEVACK:  if (scl_fall) state_nxt = rw ? RDATA : WADDR;
        WADDR:   if (scl_fall && byte_done) state_nxt = WACK;
        WACK:    if (scl_fall) state_nxt = WDATA;
        WDATA:   if (scl_fall && byte_done) state_nxt = wp_block ? IDLE : WACK;
        RDATA:   if (scl_fall && byte_done) state_nxt = RACK;
        RACK: begin
          if (scl_rise && sda_s) state_nxt = IDLE;
          else if (scl_fall)     state_nxt = RDATA;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and bus outputs; every sda_oe change is tied to an scl fall.
  always_comb begin
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    rw_nxt       = rw;
    ptr_nxt      = ptr;
    wr_pulse_nxt = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    mem_we       = 1'b0;
    if (stop_det) begin
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = 4'd0;
    end else if (start_det) begin
      sda_oe_nxt  = 1'b0;
      bit_cnt_nxt = 4'd0;
    end else begin
      if (scl_rise && shifting && !byte_done) begin
        shreg_nxt   = {shreg[6:0], sda_s};
        bit_cnt_nxt = bit_cnt + 4'd1;
      end
      if (scl_fall) begin
        case (state)
          DEVADDR: begin
            if (byte_done) begin
              bit_cnt_nxt = 4'd0;
              if (addr_match) begin
                sda_oe_nxt = 1'b1;
                rw_nxt     = shreg[0];
                busy_nxt   = 1'b1;
              end else begin
                busy_nxt   = 1'b0;
              end
            end
          end
          DEVACK: begin
            if (rw) begin
              shreg_nxt   = mem_rd;
              sda_oe_nxt  = ~mem_rd[7];
              bit_cnt_nxt = 4'd1;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 4'd0;
            end
          end
          WADDR: begin
            if (byte_done) begin
              sda_oe_nxt  = 1'b1;
              ptr_nxt     = shreg[AW-1:0];
              bit_cnt_nxt = 4'd0;
            end
          end
          WACK: begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 4'd0;
          end
          WDATA: begin
            if (byte_done) begin
              bit_cnt_nxt = 4'd0;
              ptr_nxt     = ptr + AW'(1);
              if (!wp_block) begin
                sda_oe_nxt   = 1'b1;
                mem_we       = 1'b1;
                wr_pulse_nxt = 1'b1;
                wr_addr_nxt  = ptr;
                wr_data_nxt  = shreg;
              end
            end
          end
          RDATA: begin
            if (byte_done) begin
              sda_oe_nxt  = 1'b0;
              ptr_nxt     = ptr + AW'(1);
              bit_cnt_nxt = 4'd0;
            end else begin
              sda_oe_nxt  = ~shreg[6];
              shreg_nxt   = {shreg[6:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
          RACK: begin
            shreg_nxt   = mem_rd;
            sda_oe_nxt  = ~mem_rd[7];
            bit_cnt_nxt = 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      rw       <= 1'b0;
      ptr      <= '0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'h00;
    end else begin
      sda_oe   <= sda_oe_nxt;
      busy     <= busy_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      rw       <= rw_nxt;
      ptr      <= ptr_nxt;
      wr_pulse <= wr_pulse_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
    end
  end

  // Storage is deliberately left out of reset, like a real EEPROM array.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= shreg;
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bit-banged I2C master driving i2c_eeprom_slave, checked against an array model of the EEPROM.
// Define I2C_EEPROM_WP_EN to also exercise the write-protect input.
module tb_i2c_eeprom_slave;

  localparam int QTR = 5;
  localparam logic [6:0] DEV = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       wp_level = 1'b0;
  logic       sda_line;
  logic       sda_oe, busy, wr_pulse;
  logic [7:0] wr_addr, wr_data;

  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr = 8'h00;
  logic [7:0]  buf_d [8];
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int          got_rd = 0;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  int          oe_cnt = 0;
  int          scl_viol = 0;
  logic        prev_oe = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_eeprom_slave dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
`ifdef I2C_EEPROM_WP_EN
    .wp       (wp_level),
`endif
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  // Passive observers: committed writes, busy/oe activity, and sda changes while scl is high.
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) got_q.push_back({wr_addr, wr_data});
    if (busy === 1'b1) busy_cnt++;
    if (sda_oe === 1'b1) oe_cnt++;
    if (!rst && scl_m && (sda_oe !== prev_oe)) scl_viol++;
    prev_oe = sda_oe;
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    s = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
    xfer_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
    xfer_bit(~master_ack, s);
  endtask

  task automatic check_pulses(input string tag);
    check_output({tag, "_npulse"}, 16'(got_q.size() - got_rd), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (got_rd + i < got_q.size())
        check_output({tag, "_pulse"}, got_q[got_rd + i], exp_q[i]);
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  // Write n bytes from buf_d starting at waddr; protected bytes are NACKed and end the burst.
  task automatic write_txn(input logic [7:0] waddr, input int n, input string tag);
    logic ack, accepted;
    i2c_start();
    wr_byte({DEV, 1'b0}, ack);
    check_output({tag, "_devack"}, 16'(ack), 16'd1);
    wr_byte(waddr, ack);
    check_output({tag, "_addrack"}, 16'(ack), 16'd1);
    model_ptr = waddr;
    for (int i = 0; i < n; i++) begin
      wr_byte(buf_d[i], ack);
      accepted = ~wp_level;
      check_output({tag, "_dataack"}, 16'(ack), 16'(accepted));
      if (accepted) begin
        model_mem[model_ptr] = buf_d[i];
        exp_q.push_back({model_ptr, buf_d[i]});
      end
      model_ptr = model_ptr + 8'd1;
      if (!accepted) break;
    end
    check_output({tag, "_busy"}, 16'(busy), 16'd1);
    i2c_stop();
    check_output({tag, "_idle"}, 16'(busy), 16'd0);
    check_pulses(tag);
  endtask

  // Read n bytes, either from raddr (random read) or from the current pointer.
  task automatic read_txn(input logic random_rd, input logic [7:0] raddr, input int n,
                          input string tag);
    logic ack;
    logic [7:0] d;
    i2c_start();
    if (random_rd) begin
      wr_byte({DEV, 1'b0}, ack);
      check_output({tag, "_devack"}, 16'(ack), 16'd1);
      wr_byte(raddr, ack);
      check_output({tag, "_addrack"}, 16'(ack), 16'd1);
      model_ptr = raddr;
      i2c_start();
    end
    wr_byte({DEV, 1'b1}, ack);
    check_output({tag, "_rdack"}, 16'(ack), 16'd1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i != n - 1, d);
      check_output({tag, "_data"}, 16'(d), 16'(model_mem[model_ptr]));
      model_ptr = model_ptr + 8'd1;
    end
    i2c_stop();
  endtask

  initial begin : main
    logic ack, s;
    int b0, o0, n;
    logic [7:0] a;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_output("rst_sda_oe", 16'(sda_oe), 16'd0);
    check_output("rst_busy", 16'(busy), 16'd0);
    check_output("rst_wr_pulse", 16'(got_q.size()), 16'd0);

    $display("[TB] write then random read");
    buf_d[0] = 8'h5A; buf_d[1] = 8'hC3;
    write_txn(8'h10, 2, "wr_fixed");
    read_txn(1'b1, 8'h10, 2, "rd_fixed");

    $display("[TB] preload");
    buf_d[0] = 8'($urandom); buf_d[1] = 8'($urandom);
    write_txn(8'h00, 2, "pre00");
    buf_d[0] = 8'($urandom);
    write_txn(8'h20, 1, "pre20");
    buf_d[0] = 8'($urandom);
    write_txn(8'h30, 1, "pre30");

    $display("[TB] randomized bursts");
    for (int k = 0; k < 5; k++) begin
      a = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) buf_d[i] = 8'($urandom);
      write_txn(a, n, "rnd_wr");
      read_txn(1'b1, a, n, "rnd_rd");
    end

    $display("[TB] pointer wrap");
    buf_d[0] = 8'h11; buf_d[1] = 8'h22;
    write_txn(8'hFF, 2, "wrap");
    read_txn(1'b0, 8'h00, 1, "cur_rd");

    $display("[TB] address mismatch");
    b0 = busy_cnt; o0 = oe_cnt;
    i2c_start();
    wr_byte(8'hA2, ack);
    check_output("mis_ack", 16'(ack), 16'd0);
    i2c_stop();
    check_output("mis_busy", 16'(busy_cnt - b0), 16'd0);
    check_output("mis_oe", 16'(oe_cnt - o0), 16'd0);

    $display("[TB] abort mid-byte");
    i2c_start();
    wr_byte({DEV, 1'b0}, ack);
    check_output("abort_devack", 16'(ack), 16'd1);
    wr_byte(8'h20, ack);
    check_output("abort_addrack", 16'(ack), 16'd1);
    for (int i = 0; i < 4; i++) xfer_bit(1'($urandom_range(0, 1)), s);
    i2c_stop();
    check_pulses("abort");
    check_output("abort_busy", 16'(busy), 16'd0);
    read_txn(1'b1, 8'h20, 1, "abort_rd");

`ifdef I2C_EEPROM_WP_EN
    $display("[TB] write protect");
    wp_level = 1'b1;
    buf_d[0] = 8'h77;
    write_txn(8'h30, 1, "wp");
    wp_level = 1'b0;
    read_txn(1'b1, 8'h30, 1, "wp_rd");
`endif

    check_output("scl_high_oe_change", 16'(scl_viol), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
